// File: rtl/audio_synth.sv
// ---------------------------------------------------------------------------
// audio_synth
// Multi-channel tone generator feeding the single-pin PWM audio output.
// Each channel runs a square or LFSR-noise oscillator gated by a one-shot
// volume envelope that decays once per video frame. Channel levels are summed
// into a registered sample, which is turned into a single PWM bit.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   env_tick   in   one-cycle envelope decay strobe (frame rate)
//   ch_trig    in   per-channel note-on pulse
//   ch_noise   in   per-channel mode: 1 = LFSR noise, 0 = square
//   ch_period  in   per-channel half-period in clocks, 0 mutes the channel
//   ch_vol     in   per-channel envelope start level, loaded on trigger
//   sample     out  registered mixed sample
//   audio_pwm  out  registered PWM audio bit
// ---------------------------------------------------------------------------
module audio_synth #(
    parameter int CHANNELS = 2,
    parameter int PERIOD_W = 12,
    parameter int VOL_W    = 3,
    parameter int PWM_W    = 8,
    localparam int MIX_W   = VOL_W + $clog2(CHANNELS),
    localparam int SHIFT   = PWM_W - MIX_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         env_tick,
    input  logic [CHANNELS-1:0]          ch_trig,
    input  logic [CHANNELS-1:0]          ch_noise,
    input  logic [CHANNELS*PERIOD_W-1:0] ch_period,
    input  logic [CHANNELS*VOL_W-1:0]    ch_vol,
    output logic [MIX_W-1:0]             sample,
    output logic                         audio_pwm
);

    logic [PERIOD_W-1:0] r_cnt   [CHANNELS];
    logic [VOL_W-1:0]    r_env   [CHANNELS];
    logic [CHANNELS-1:0] r_phase;
    logic [14:0]         r_lfsr;
    logic [PWM_W-1:0]    r_pwmCnt;
    logic [PWM_W-1:0]    r_sampleQ;

    logic [PERIOD_W-1:0] w_period [CHANNELS];
    logic [CHANNELS-1:0] w_mute;
    logic [CHANNELS-1:0] w_reload;
    logic                w_noiseStep;
    logic [MIX_W-1:0]    w_mix;

    // Per-channel decode. The reload test uses ">=" so that shrinking the
    // period below the running count still reloads on the very next clock
    // instead of running on until the counter wraps.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_period[i] = ch_period[i*PERIOD_W +: PERIOD_W];
            w_mute[i]   = (w_period[i] == '0);
            w_reload[i] = !ch_trig[i] && !w_mute[i] &&
                          (r_cnt[i] >= (w_period[i] - PERIOD_W'(1)));
        end
    end

    // The shared LFSR advances once per clock no matter how many noise
    // channels reload together, so all of them see the same pre-step bit.
    assign w_noiseStep = |(w_reload & ch_noise);

    // Mixer: sum of envelope levels of channels whose phase is high. MIX_W
    // carries enough guard bits that the sum cannot overflow.
    always_comb begin
        w_mix = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_phase[i]) begin
                w_mix = w_mix + MIX_W'(r_env[i]);
            end
        end
    end

    // Oscillators and envelopes. Trigger outranks mute, reload and decay.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= '0;
                r_env[i] <= '0;
            end
            r_phase <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (ch_trig[i]) begin
                    r_cnt[i]   <= '0;
                    r_phase[i] <= 1'b1;
                end else if (w_mute[i]) begin
                    r_cnt[i]   <= '0;
                    r_phase[i] <= 1'b0;
                end else if (w_reload[i]) begin
                    r_cnt[i]   <= '0;
                    r_phase[i] <= ch_noise[i] ? r_lfsr[0] : ~r_phase[i];
                end else begin
                    r_cnt[i]   <= r_cnt[i] + PERIOD_W'(1);
                end

                if (ch_trig[i]) begin
                    r_env[i] <= ch_vol[i*VOL_W +: VOL_W];
                end else if (env_tick && (r_env[i] != '0)) begin
                    r_env[i] <= r_env[i] - VOL_W'(1);
                end
            end
        end
    end

    // Noise source: x^15 + x^14 + 1 is maximal length, so starting from a
    // non-zero seed the register can never reach the all-zero lock-up state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= 15'h7FFF;
        end else if (w_noiseStep) begin
            r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
        end
    end

    // Mixed sample and PWM stage. The duty value is captured only on the last
    // count of a period so each PWM period is driven by one stable level; the
    // strict "<" compare keeps the duty below 100%.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample    <= '0;
            r_sampleQ <= '0;
            r_pwmCnt  <= '0;
            audio_pwm <= 1'b0;
        end else begin
            sample   <= w_mix;
            r_pwmCnt <= r_pwmCnt + PWM_W'(1);
            if (&r_pwmCnt) begin
                r_sampleQ <= PWM_W'(sample) << SHIFT;
            end
            audio_pwm <= (r_pwmCnt < r_sampleQ);
        end
    end

endmodule

// File: tb/tb_audio_synth.sv
// ---------------------------------------------------------------------------
// tb_audio_synth
// Self-checking bench for audio_synth (CHANNELS=2, PERIOD_W=12, VOL_W=3,
// PWM_W=8). Expected samples come from closed-form tone arithmetic and a
// standalone LFSR sequence; PWM duty is measured as high clocks per 256.
// ---------------------------------------------------------------------------
module tb_audio_synth;

    localparam int PW = 12;
    localparam int VW = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        env_tick;
    logic [1:0]  ch_trig;
    logic [1:0]  ch_noise;
    logic [23:0] ch_period;
    logic [5:0]  ch_vol;
    logic [3:0]  sample;
    logic        audio_pwm;

    int checks = 0;
    int fails  = 0;

    audio_synth #(
        .CHANNELS (2),
        .PERIOD_W (12),
        .VOL_W    (3),
        .PWM_W    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .env_tick  (env_tick),
        .ch_trig   (ch_trig),
        .ch_noise  (ch_noise),
        .ch_period (ch_period),
        .ch_vol    (ch_vol),
        .sample    (sample),
        .audio_pwm (audio_pwm)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are read on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic setCh(input int c, input int period, input int vol);
        ch_period[c*PW +: PW] = PW'(period);
        ch_vol[c*VW +: VW]    = VW'(vol);
    endtask

    // Square phase j clocks after trigger: high for `p` clocks, low for `p`.
    function automatic int sqPh(input int j, input int p);
        return ((j / p) % 2 == 0) ? 1 : 0;
    endfunction

    task automatic applyReset();
        rst_n = 1'b0; env_tick = 1'b0; ch_trig = '0; ch_noise = '0;
        ch_period = '0; ch_vol = '0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int hi;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            env_tick  = 1'($urandom);
            ch_trig   = 2'($urandom);
            ch_noise  = 2'($urandom);
            ch_period = 24'($urandom);
            ch_vol    = 6'($urandom);
            step();
            checks++;
            if (sample !== 4'd0) begin
                fails++;
                $display("[TB] FAIL reset_sample cyc=%0d got=%0d exp=0", i, sample);
            end
            checks++;
            if (audio_pwm !== 1'b0) begin
                fails++;
                $display("[TB] FAIL reset_pwm cyc=%0d got=%b exp=0", i, audio_pwm);
            end
        end
        env_tick = 1'b0; ch_trig = '0; ch_noise = '0; ch_period = '0; ch_vol = '0;
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            hi += int'(audio_pwm);
        end
        checks++;
        if (hi != 0) begin
            fails++;
            $display("[TB] FAIL reset_first_period high=%0d exp=0", hi);
        end
    endtask

    task automatic test_square();
        int exp;
        ch_noise = '0;
        setCh(0, 4, 7); setCh(1, 0, 0);
        ch_trig = 2'b01;
        step();
        ch_trig = '0;
        for (int k = 1; k <= 32; k++) begin
            step();
            exp = 7 * sqPh(k - 1, 4);
            checks++;
            if (int'(sample) != exp) begin
                fails++;
                $display("[TB] FAIL square k=%0d got=%0d exp=%0d", k, sample, exp);
            end
        end
    endtask

    task automatic measurePwm(input string name, input int p0, input int v0,
                              input int p1, input int v1);
        int hi;
        int expSample;
        ch_noise = '0;
        setCh(0, p0, v0); setCh(1, p1, v1);
        ch_trig = 2'b11;
        step();
        ch_trig = '0;
        repeat (300) step();
        expSample = (p0 != 0 ? v0 : 0) + (p1 != 0 ? v1 : 0);
        checks++;
        if (int'(sample) != expSample) begin
            fails++;
            $display("[TB] FAIL %s_sample got=%0d exp=%0d", name, sample, expSample);
        end
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            hi += int'(audio_pwm);
        end
        checks++;
        if (hi != expSample * 16) begin
            fails++;
            $display("[TB] FAIL %s_high got=%0d exp=%0d", name, hi, expSample * 16);
        end
    endtask

    task automatic test_pwm_single();
        measurePwm("pwm_7", 4095, 7, 0, 0);
        measurePwm("pwm_rand", 4095, int'($urandom_range(1, 6)), 0, 0);
    endtask

    task automatic pulseTicks(input int n);
        for (int i = 0; i < n; i++) begin
            env_tick = 1'b1;
            step();
            env_tick = 1'b0;
            step();
        end
    endtask

    task automatic test_envelope();
        ch_noise = '0;
        setCh(0, 4095, 7); setCh(1, 0, 0);
        ch_trig = 2'b01;
        step();
        ch_trig = '0;
        step();
        pulseTicks(3);
        step();
        checks++;
        if (sample !== 4'd4) begin
            fails++;
            $display("[TB] FAIL env_after3 got=%0d exp=4", sample);
        end
        setCh(0, 4095, int'($urandom_range(0, 3)));
        repeat (4) step();
        checks++;
        if (sample !== 4'd4) begin
            fails++;
            $display("[TB] FAIL env_vol_no_trig got=%0d exp=4", sample);
        end
        pulseTicks(10);
        step();
        checks++;
        if (sample !== 4'd0) begin
            fails++;
            $display("[TB] FAIL env_floor got=%0d exp=0", sample);
        end
        setCh(0, 4095, 7);
        ch_trig  = 2'b01;
        env_tick = 1'b1;
        step();
        ch_trig  = '0;
        env_tick = 1'b0;
        step(); step();
        checks++;
        if (sample !== 4'd7) begin
            fails++;
            $display("[TB] FAIL env_trig_tick got=%0d exp=7", sample);
        end
    endtask

    task automatic runSquarePair(input string name, input int p0, input int v0,
                                 input int p1, input int v1, input int n);
        int exp;
        ch_noise = '0;
        setCh(0, p0, v0); setCh(1, p1, v1);
        ch_trig = 2'b11;
        step();
        ch_trig = '0;
        for (int k = 1; k <= n; k++) begin
            step();
            exp = v0 * sqPh(k - 1, p0) + v1 * sqPh(k - 1, p1);
            checks++;
            if (int'(sample) != exp) begin
                fails++;
                $display("[TB] FAIL %s k=%0d p=%0d/%0d v=%0d/%0d got=%0d exp=%0d",
                         name, k, p0, p1, v0, v1, sample, exp);
            end
        end
    endtask

    task automatic test_two_channel();
        runSquarePair("mix2", 8, 7, 8, 7, 40);
        measurePwm("pwm_mix2", 4095, 7, 4095, 7);
    endtask

    task automatic test_random_square();
        for (int r = 0; r < 4; r++) begin
            runSquarePair("rand_sq",
                          int'($urandom_range(1, 9)), int'($urandom_range(0, 7)),
                          int'($urandom_range(1, 9)), int'($urandom_range(0, 7)), 60);
        end
    endtask

    task automatic test_period_change();
        int expSeq [4] = '{7, 0, 0, 7};
        ch_noise = '0;
        setCh(0, 100, 7); setCh(1, 0, 0);
        ch_trig = 2'b01;
        step();
        ch_trig = '0;
        repeat (50) step();
        checks++;
        if (sample !== 4'd7) begin
            fails++;
            $display("[TB] FAIL period_cut_pre got=%0d exp=7", sample);
        end
        setCh(0, 2, 7);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (int'(sample) != expSeq[i]) begin
                fails++;
                $display("[TB] FAIL period_cut i=%0d got=%0d exp=%0d", i, sample, expSeq[i]);
            end
        end
    endtask

    // Noise channels with period 1 reload every clock after the trigger. Phase
    // right after the trigger is 1; afterwards it is bit 0 of successive LFSR
    // states from the 7FFF seed, one state per clock regardless of channel count.
    task automatic runNoise(input string name, input logic [1:0] chans,
                            input int v0, input int v1);
        int   ph [121];
        int   exp;
        int   vsum;
        logic [14:0] lf;
        lf = 15'h7FFF;
        ph[0] = 1;
        for (int j = 1; j <= 120; j++) begin
            ph[j] = int'(lf[0]);
            lf = {lf[13:0], lf[14] ^ lf[13]};
        end
        applyReset();
        ch_noise = chans;
        setCh(0, chans[0] ? 1 : 0, v0);
        setCh(1, chans[1] ? 1 : 0, v1);
        vsum = (chans[0] ? v0 : 0) + (chans[1] ? v1 : 0);
        ch_trig = chans;
        step();
        ch_trig = '0;
        for (int k = 1; k <= 120; k++) begin
            step();
            exp = vsum * ph[k - 1];
            checks++;
            if (int'(sample) != exp) begin
                fails++;
                $display("[TB] FAIL %s k=%0d got=%0d exp=%0d", name, k, sample, exp);
            end
        end
        ch_noise = '0;
    endtask

    task automatic test_noise();
        runNoise("noise1", 2'b10, 0, 7);
        runNoise("noise2", 2'b11, int'($urandom_range(1, 7)), int'($urandom_range(1, 7)));
    endtask

    task automatic test_midreset();
        int hi;
        ch_noise = '0;
        setCh(0, 4095, 7); setCh(1, 4095, int'($urandom_range(1, 7)));
        ch_trig = 2'b11;
        step();
        ch_trig = '0;
        repeat (300) step();
        rst_n = 1'b0;
        step();
        checks++;
        if (sample !== 4'd0) begin
            fails++;
            $display("[TB] FAIL midreset_sample got=%0d exp=0", sample);
        end
        checks++;
        if (audio_pwm !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset_pwm got=%b exp=0", audio_pwm);
        end
        rst_n = 1'b1;
        setCh(0, 4, 7); setCh(1, 3, 7);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            hi += int'(audio_pwm);
            if (i < 24) begin
                checks++;
                if (sample !== 4'd0) begin
                    fails++;
                    $display("[TB] FAIL midreset_env i=%0d got=%0d exp=0", i, sample);
                end
            end
        end
        checks++;
        if (hi != 0) begin
            fails++;
            $display("[TB] FAIL midreset_period high=%0d exp=0", hi);
        end
    endtask

    initial begin
        rst_n = 1'b0; env_tick = 1'b0; ch_trig = '0; ch_noise = '0;
        ch_period = '0; ch_vol = '0;
        test_reset();
        test_square();
        test_pwm_single();
        test_envelope();
        test_two_channel();
        test_random_square();
        test_period_change();
        test_noise();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
